// File: rtl/fetch_unit.sv
// Two-wide instruction fetch unit: fetches 32-bit aligned pairs into a small
// queue and presents the two head entries to decode, with redirect and flush.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] address,
    input  logic [31:0] inst_bus,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out0_valid,
    output logic        out1_valid,
    output logic [15:0] out0_inst,
    output logic [15:0] out1_inst,
    output logic [15:0] out0_pc,
    output logic [15:0] out1_pc,
    input  logic [1:0]  dec_accept
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t          state, state_next;
    logic [15:0]     fetch_pc, fetch_pc_next;
    logic            skip_upper, skip_next;
    logic [15:0]     q_inst [QDEPTH];
    logic [15:0]     q_pc   [QDEPTH];
    logic [PW-1:0]   head, tail, head_next, tail_next, head_plus1, tail_plus1;
    logic [CW-1:0]   count, count_next;
    logic [1:0]      removed, added;
    logic            do_fetch;

    // Pointer add modulo QDEPTH; QDEPTH need not be a power of two.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] n);
        int unsigned s;
        s = 32'(p) + 32'(n);
        if (s >= QDEPTH) s = s - QDEPTH;
        return PW'(s);
    endfunction

    assign head_plus1 = wrap_add(head, 2'd1);
    assign tail_plus1 = wrap_add(tail, 2'd1);

    always_comb begin
        removed       = '0;
        added         = '0;
        do_fetch      = 1'b0;
        fetch_pc_next = fetch_pc;
        skip_next     = skip_upper;
        head_next     = head;
        tail_next     = tail;
        count_next    = count;
        if (redirect_valid) begin
            fetch_pc_next = {redirect_pc[15:1], 1'b0};
            skip_next     = redirect_pc[0];
            head_next     = '0;
            tail_next     = '0;
            count_next    = '0;
        end else begin
            // Decode may over-request; only entries actually present are removed.
            if (dec_accept >= 2'd2 && count >= CW'(2))
                removed = 2'd2;
            else if (dec_accept != 2'd0 && count != '0)
                removed = 2'd1;
            if (state == FETCH) begin
                do_fetch      = 1'b1;
                added         = skip_upper ? 2'd1 : 2'd2;
                fetch_pc_next = fetch_pc + 16'd2;
                skip_next     = 1'b0;
            end
            head_next  = wrap_add(head, removed);
            tail_next  = wrap_add(tail, added);
            count_next = count - CW'(removed) + CW'(added);
        end
        state_next = ((QDEPTH - 32'(count_next)) >= 2) ? FETCH : HOLD;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            skip_upper <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            skip_upper <= skip_next;
            head       <= head_next;
            tail       <= tail_next;
            count      <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (do_fetch && !reset) begin
            if (skip_upper) begin
                q_inst[tail] <= inst_bus[15:0];
                q_pc[tail]   <= fetch_pc + 16'd1;
            end else begin
                q_inst[tail]       <= inst_bus[31:16];
                q_pc[tail]         <= fetch_pc;
                q_inst[tail_plus1] <= inst_bus[15:0];
                q_pc[tail_plus1]   <= fetch_pc + 16'd1;
            end
        end
    end

    assign address    = fetch_pc;
    assign out0_valid = (count != '0);
    assign out1_valid = (count >= CW'(2));
    assign out0_inst  = q_inst[head];
    assign out0_pc    = q_pc[head];
    assign out1_inst  = q_inst[head_plus1];
    assign out1_pc    = q_pc[head_plus1];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fill/hold, dequeue clamping,
// odd redirects, address wrap and reset overriding redirect.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [15:0] address;
    logic [31:0] inst_bus;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out0_valid, out1_valid;
    logic [15:0] out0_inst, out1_inst, out0_pc, out1_pc;
    logic [1:0]  dec_accept;

    int vectors     = 0;
    int miscompares = 0;

    fetch_unit #(.RESET_PC(16'h0000), .QDEPTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .inst_bus(inst_bus),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out0_valid(out0_valid),
        .out1_valid(out1_valid),
        .out0_inst(out0_inst),
        .out1_inst(out1_inst),
        .out0_pc(out0_pc),
        .out1_pc(out1_pc),
        .dec_accept(dec_accept)
    );

    // Memory image: words 0/1 are FFFF, 2/3 are 3002/3401, else pc ^ 1234.
    function automatic logic [15:0] inst_at(input logic [15:0] p);
        case (p)
            16'h0000, 16'h0001: return 16'hFFFF;
            16'h0002:           return 16'h3002;
            16'h0003:           return 16'h3401;
            default:            return p ^ 16'h1234;
        endcase
    endfunction

    assign inst_bus = {inst_at(address), inst_at(address + 16'd1)};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000; dec_accept = 2'd0;
        step(); step();
        check("rst_addr", address, 16'h0000);
        check("rst_v0", 16'(out0_valid), 16'd0);
        check("rst_v1", 16'(out1_valid), 16'd0);

        reset = 1'b0;
        step();
        check("f1_v0", 16'(out0_valid), 16'd1);
        check("f1_i0", out0_inst, 16'hFFFF);
        check("f1_p0", out0_pc, 16'h0000);
        check("f1_v1", 16'(out1_valid), 16'd1);
        check("f1_i1", out1_inst, 16'hFFFF);
        check("f1_p1", out1_pc, 16'h0001);
        check("f1_addr", address, 16'h0002);

        step();
        check("full_addr", address, 16'h0004);
        check("full_p0", out0_pc, 16'h0000);
        step();
        check("hold_addr", address, 16'h0004);
        check("hold_p0", out0_pc, 16'h0000);
        check("hold_p1", out1_pc, 16'h0001);

        dec_accept = 2'd2;
        step();
        check("deq_i0", out0_inst, 16'h3002);
        check("deq_p0", out0_pc, 16'h0002);
        check("deq_i1", out1_inst, 16'h3401);
        check("deq_p1", out1_pc, 16'h0003);
        check("deq_addr", address, 16'h0004);

        dec_accept = 2'd0;
        step();
        check("resume_addr", address, 16'h0006);
        check("resume_p0", out0_pc, 16'h0002);

        dec_accept = 2'd1;
        step();
        check("deq1_p0", out0_pc, 16'h0003);
        check("deq1_i1", out1_inst, 16'h1230);
        check("deq1_addr", address, 16'h0006);
        step();
        dec_accept = 2'd0;
        step();
        check("refill_p0", out0_pc, 16'h0004);
        check("refill_addr", address, 16'h0008);

        redirect_valid = 1'b1; redirect_pc = 16'h0081; dec_accept = 2'd2;
        step();
        check("redir_addr", address, 16'h0080);
        check("redir_v0", 16'(out0_valid), 16'd0);
        check("redir_v1", 16'(out1_valid), 16'd0);

        redirect_valid = 1'b0; dec_accept = 2'd0;
        step();
        check("odd_v0", 16'(out0_valid), 16'd1);
        check("odd_p0", out0_pc, 16'h0081);
        check("odd_i0", out0_inst, 16'h12B5);
        check("odd_v1", 16'(out1_valid), 16'd0);
        check("odd_addr", address, 16'h0082);
        step();
        check("odd2_v1", 16'(out1_valid), 16'd1);
        check("odd2_p1", out1_pc, 16'h0082);

        redirect_valid = 1'b1; redirect_pc = 16'hFFFE; dec_accept = 2'd2;
        step();
        check("wrap_addr0", address, 16'hFFFE);
        check("wrap_v0", 16'(out0_valid), 16'd0);
        redirect_valid = 1'b0;
        step();
        check("wrap_p0", out0_pc, 16'hFFFE);
        check("wrap_i0", out0_inst, 16'hEDCA);
        check("wrap_p1", out1_pc, 16'hFFFF);
        check("wrap_i1", out1_inst, 16'hEDCB);
        check("wrap_addr1", address, 16'h0000);
        step();
        check("wrap_p2", out0_pc, 16'h0000);
        check("wrap_i2", out0_inst, 16'hFFFF);
        check("wrap_p3", out1_pc, 16'h0001);
        check("wrap_addr2", address, 16'h0002);

        redirect_valid = 1'b1; redirect_pc = 16'h0011;
        step();
        redirect_valid = 1'b0;
        step();
        check("clamp_p0a", out0_pc, 16'h0011);
        check("clamp_v1a", 16'(out1_valid), 16'd0);
        step();
        check("clamp_p0b", out0_pc, 16'h0012);
        check("clamp_p1b", out1_pc, 16'h0013);
        check("clamp_v1b", 16'(out1_valid), 16'd1);

        dec_accept = 2'd1;
        step();
        check("three_p0", out0_pc, 16'h0013);
        check("three_v1", 16'(out1_valid), 16'd1);

        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0200; dec_accept = 2'd2;
        step();
        check("rst2_v0", 16'(out0_valid), 16'd0);
        check("rst2_v1", 16'(out1_valid), 16'd0);
        check("rst2_addr", address, 16'h0000);

        reset = 1'b0; redirect_valid = 1'b0; dec_accept = 2'd0;
        step();
        check("post_p0", out0_pc, 16'h0000);
        check("post_i0", out0_inst, 16'hFFFF);
        check("post_addr", address, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001: Parameter RESET_PC, default 16'h0000: PC loaded on reset; bit 0 SHALL be zero.
REQ-002: Parameter QDEPTH, default 4: fetch-queue depth in 16-bit instructions; SHALL be even and at least 4.
REQ-003: clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: address  output  16  word address to the instruction memory; bit 0 is always 0.
REQ-006: inst_bus  input  32  combinational memory read data for address; [31:16] is the instruction at address, [15:0] is the instruction at address+1.
REQ-007: redirect_valid  input  1  branch/jump redirect request.
REQ-008: redirect_pc  input  16  redirect target; may be odd.
REQ-009: out0_valid, out1_valid  output  1 each  head and head+1 queue entries valid.
REQ-010: out0_inst, out1_inst  output  16 each  instructions at queue head and head+1.
REQ-011: out0_pc, out1_pc  output  16 each  PCs of those instructions.
REQ-012: dec_accept  input  2  number of instructions decode consumes this cycle: 0, 1 or 2.

Function
REQ-013: Internal state SHALL be fetch_pc[15:0] (even), skip_upper flag, queue storage of QDEPTH {inst, pc} entries, head/tail pointers and count.
REQ-014: address SHALL equal fetch_pc, driven from a register; no combinational path from any input to address.
REQ-015: FSM SHALL have two states: FETCH when QDEPTH-count >= 2 (registered count, no same-cycle credit from dec_accept), and HOLD otherwise.
REQ-016: In FETCH without redirect, the unit SHALL enqueue {inst_bus[31:16], fetch_pc} then {inst_bus[15:0], fetch_pc+1} at the edge and advance fetch_pc by 2.
REQ-017: If skip_upper=1 during a fetch, only {inst_bus[15:0], fetch_pc+1} SHALL be enqueued, and skip_upper SHALL clear.
REQ-018: In HOLD, fetch_pc and the queue tail SHALL be unchanged and nothing SHALL be enqueued.
REQ-019: Dequeue: the unit SHALL remove min(dec_accept, valid count) entries from the head; dec_accept exceeding the valid count is a protocol error and SHALL be clamped.
REQ-020: Enqueue and dequeue SHALL occur in the same cycle; the new count SHALL be count - removed + added.
REQ-021: out0/out1 SHALL reflect the queue head combinationally from registers; out1_valid SHALL imply out0_valid.
REQ-022: Redirect has priority over fetch and dequeue: the queue SHALL flush (count=0), nothing SHALL be enqueued, dec_accept SHALL be ignored, fetch_pc SHALL become {redirect_pc[15:1],1'b0}, and skip_upper SHALL become redirect_pc[0].
REQ-023: Outputs SHALL show out0_valid=out1_valid=0 the cycle after a redirect, and the first redirected instruction SHALL appear one cycle later.
REQ-024: fetch_pc SHALL wrap modulo 2^16 (16'hFFFE + 2 = 16'h0000); stored pc of the lower half at 16'hFFFE SHALL be 16'hFFFF.
REQ-025: Instructions, including 16'hFFFF NOPs, SHALL be enqueued unmodified; the unit does no decode.
REQ-026: Queue pointers SHALL wrap modulo QDEPTH; overflow SHALL be impossible by construction of REQ-015.

Reset
REQ-027: On reset=1 at an edge: fetch_pc=RESET_PC, skip_upper=0, count=0, pointers=0, and all out*_valid=0, overriding redirect and dec_accept.
REQ-028: After reset the unit SHALL be in FETCH; the first enqueue SHALL occur on the first edge with reset=0.
REQ-029: Reset asserted mid-operation SHALL discard queue contents with no instruction delivered after the reset edge.

Verification
REQ-030: Reset then release, memory[0]=32'hFFFFFFFF, memory[2]=32'h30023401 -> cycle 0 address=0x0000, no valid; cycle 1 out0=FFFF/pc0, out1=FFFF/pc1, address=0x0002.
REQ-031: dec_accept=0 held, QDEPTH=4 -> after 2 fetches count=4, FSM in HOLD, address stuck at 0x0004, outputs stable; then dec_accept=2 for one cycle -> next edge count=2, subsequent fetch resumes at 0x0004.
REQ-032: Redirect to 0x0081 -> next cycle address=0x0080, valids=0; following cycle only out0 valid, pc=0x0081, inst=memory[0x80][15:0]; address=0x0082.
REQ-033: Redirect asserted with queue full and dec_accept=2 -> queue flushed, no dequeue counted, address=redirect target aligned.
REQ-034: Redirect to 0xFFFE with dec_accept=2 continuously -> pcs FFFE, FFFF, 0000, 0001 delivered in order.
REQ-035: Reset asserted with 3 valid entries and redirect_valid=1 -> next cycle valids=0, address=RESET_PC.
